// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline stage registers: bundle widths,
// control-field bit positions and the bubble control value.
package pipe_pkg;

    // Default data bundle width (pc, operands, imm, reg ids, functs)
    localparam int DATA_W_DEF    = 160;

    // Control bundle widths at each stage boundary
    localparam int CTRL_W_ID_EX  = 9;
    localparam int CTRL_W_EX_MEM = 5;
    localparam int CTRL_W_MEM_WB = 2;

    // Control-field bit offsets within the ID/EX control bundle
    localparam int CB_REGWRITE   = 0;
    localparam int CB_MEMTOREG   = 1;
    localparam int CB_MEMREAD    = 2;
    localparam int CB_MEMWRITE   = 3;
    localparam int CB_BRANCH     = 4;
    localparam int CB_JUMP       = 5;
    localparam int CB_ALUSRC     = 6;
    localparam int CB_ALUOP      = 7;   // 2 bits: [8:7]

    // Bubble control: all zero, so RegWrite=MemWrite=Branch=Jump=0
    localparam logic [CTRL_W_ID_EX-1:0] CTRL_NOP_DEF = '0;

    // Number of held entries from the two slot valid bits
    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: {valid, data, ctrl} with load and clear enables.
// Clear only drops valid; data/ctrl are held so a flush costs no datapath toggles.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_in,
    input  logic [CTRL_W-1:0] c_in,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Entry register: clear wins over load, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_in;
            ctrl  <= c_in;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline stage register with flush. SKID=0 is a single
// entry with a combinational ready path; SKID=1 adds a second (skid) entry so
// in_ready comes straight from a flop. out_* always shows the main entry.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                CTRL_W   = CTRL_W_ID_EX,
    parameter bit                SKID     = 1'b0,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              acc;
    logic              emit;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d;
    logic [CTRL_W-1:0] main_c;

    assign acc  = in_valid && in_ready;
    assign emit = main_valid && out_ready;

    // Main slot: refill from skid when it holds the next entry, else from input.
    // A load happens on an accept into an empty/draining main, or when the skid
    // entry advances. Flush voids both handshakes.
    assign main_load  = !flush && ((acc && (!main_valid || emit)) || (skid_valid && emit));
    assign main_clear = flush || (emit && !acc && !skid_valid);
    assign main_d     = skid_valid ? skid_data : in_data;
    assign main_c     = skid_valid ? skid_ctrl : in_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clear (main_clear),
        .d_in  (main_d),
        .c_in  (main_c),
        .valid (main_valid),
        .data  (main_data),
        .ctrl  (main_ctrl)
    );

    generate
        if (SKID) begin : g_skid
            logic skid_load;
            logic skid_clear;

            // Skid catches an accept that arrives while main is held by a stall
            assign skid_load  = !flush && acc && main_valid && !emit;
            assign skid_clear = flush || (skid_valid && emit);

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (skid_load),
                .clear (skid_clear),
                .d_in  (in_data),
                .c_in  (in_ctrl),
                .valid (skid_valid),
                .data  (skid_data),
                .ctrl  (skid_ctrl)
            );

            // Skid valid implies main valid, so !skid_valid == (occupancy != 2)
            assign in_ready = !skid_valid;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
            assign in_ready   = !main_valid || out_ready;
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_data  = main_data;
    // Gate control so a bubble never carries stale RegWrite/MemWrite etc.
    assign out_ctrl  = main_valid ? main_ctrl : CTRL_NOP;
    assign occupancy = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: one SKID=0 and one SKID=1 instance run the
// same step sequence, followed by a short random run against a queue model.
module tb_pipe_stage_hs;

    logic       clk;
    logic       rst_n;
    logic       iv   [2];
    logic       ir   [2];
    logic [7:0] id   [2];
    logic [3:0] ic   [2];
    logic       fl   [2];
    logic       ov   [2];
    logic       ordy [2];
    logic [7:0] od   [2];
    logic [3:0] oc   [2];
    logic [1:0] occ  [2];

    int passes = 0;
    int total  = 0;

    pipe_stage_hs #(.DATA_W(8), .CTRL_W(4), .SKID(1'b0), .CTRL_NOP(4'h0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .in_ctrl(ic[0]), .flush(fl[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_data(od[0]), .out_ctrl(oc[0]), .occupancy(occ[0])
    );

    pipe_stage_hs #(.DATA_W(8), .CTRL_W(4), .SKID(1'b1), .CTRL_NOP(4'h0)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .in_ctrl(ic[1]), .flush(fl[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_data(od[1]), .out_ctrl(oc[1]), .occupancy(occ[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int s, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s skid=%0d observed=%h expected=%h", tag, s, obs, exp);
    endtask

    // Advance one edge and land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int s);
        logic [11:0] q[$];
        logic [11:0] head;
        logic        a, e, f;

        // 1. reset asserted mid-stream
        ordy[s] = 1'b0; iv[s] = 1'b1; id[s] = 8'hA5; ic[s] = 4'h5;
        step();
        chk("load_v", s, ov[s], 1);
        chk("load_d", s, od[s], 8'hA5);
        chk("load_c", s, oc[s], 4'h5);
        iv[s] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_v", s, ov[s], 0);
        chk("mrst_c", s, oc[s], 4'h0);
        chk("mrst_occ", s, occ[s], 0);
        rst_n = 1'b1;

        // 2. streaming 1..10, one per cycle, 1-cycle latency
        ordy[s] = 1'b1; iv[s] = 1'b1; ic[s] = 4'h9;
        for (int i = 1; i <= 10; i++) begin
            id[s] = 8'(i);
            step();
            chk("strm_v", s, ov[s], 1);
            chk("strm_d", s, od[s], i);
        end
        iv[s] = 1'b0;
        step();
        chk("strm_end", s, ov[s], 0);

        // 3. stall with 8'h11 at the head
        ordy[s] = 1'b0; iv[s] = 1'b1; id[s] = 8'h11; ic[s] = 4'hC;
        step();
        chk("stall_d0", s, od[s], 8'h11);
        chk("stall_c0", s, oc[s], 4'hC);
        id[s] = 8'h22; ic[s] = 4'hD;
        #1;
        chk("stall_ir1", s, ir[s], (s == 1) ? 1 : 0);
        step();
        chk("stall_d1", s, od[s], 8'h11);
        chk("stall_occ", s, occ[s], (s == 1) ? 2 : 1);
        chk("stall_ir2", s, ir[s], 0);
        iv[s] = 1'b0;
        step();
        chk("stall_d2", s, od[s], 8'h11);
        step();
        chk("stall_d3", s, od[s], 8'h11);
        chk("stall_v3", s, ov[s], 1);
        ordy[s] = 1'b1;
        if (s == 0) iv[s] = 1'b1;   // single-entry stage never took 8'h22
        #1;
        chk("rel_d11", s, od[s], 8'h11);
        step();
        chk("rel_d22", s, od[s], 8'h22);
        chk("rel_c22", s, oc[s], 4'hD);
        chk("rel_occ", s, occ[s], 1);
        iv[s] = 1'b0;
        step();
        chk("rel_v", s, ov[s], 0);
        chk("rel_c", s, oc[s], 4'h0);

        // 4. flush with a full stage and 8'h33 offered
        ordy[s] = 1'b0; iv[s] = 1'b1; id[s] = 8'h55; ic[s] = 4'h3;
        step();
        id[s] = 8'h66;
        step();
        chk("fl_full", s, occ[s], (s == 1) ? 2 : 1);
        id[s] = 8'h33; fl[s] = 1'b1;
        step();
        chk("fl_occ", s, occ[s], 0);
        chk("fl_v", s, ov[s], 0);
        chk("fl_c", s, oc[s], 4'h0);
        fl[s] = 1'b0; iv[s] = 1'b0; ordy[s] = 1'b1;
        step();
        chk("fl_no33", s, ov[s], 0);

        // 5. flush on the same edge as an emit, then 8'h44
        iv[s] = 1'b1; id[s] = 8'h77;
        step();
        chk("fe_d77", s, od[s], 8'h77);
        iv[s] = 1'b0; fl[s] = 1'b1;
        step();
        chk("fe_bub", s, ov[s], 0);
        fl[s] = 1'b0; iv[s] = 1'b1; id[s] = 8'h44; ic[s] = 4'h6;
        step();
        chk("fe_d44", s, od[s], 8'h44);
        chk("fe_c44", s, oc[s], 4'h6);
        iv[s] = 1'b0;
        step();
        chk("fe_end", s, ov[s], 0);

        // 6. random valid/ready/flush against a FIFO model
        for (int c = 0; c < 2000; c++) begin
            iv[s]   = ($urandom_range(99) < 70);
            ordy[s] = ($urandom_range(99) < 60);
            fl[s]   = ($urandom_range(99) < 5);
            id[s]   = 8'($urandom);
            ic[s]   = 4'($urandom);
            #1;
            a = iv[s] && ir[s];
            e = ov[s] && ordy[s];
            f = fl[s];
            chk("rnd_occ", s, occ[s], q.size());
            if (!ov[s]) chk("rnd_nop", s, oc[s], 4'h0);
            if (s == 1) chk("rnd_ir", s, ir[s], (occ[s] != 2'd2));
            if (f) begin
                q.delete();
            end else begin
                if (e) begin
                    head = (q.size() > 0) ? q.pop_front() : 12'hxxx;
                    chk("rnd_emit", s, {oc[s], od[s]}, head);
                end
                if (a) q.push_back({ic[s], id[s]});
            end
            step();
        end
        iv[s] = 1'b0; fl[s] = 1'b1;
        step();
        fl[s] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; id[k] = 8'h00; ic[k] = 4'h0; fl[k] = 1'b0; ordy[k] = 1'b0;
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            chk("rst_v", k, ov[k], 0);
            chk("rst_c", k, oc[k], 4'h0);
            chk("rst_d", k, od[k], 8'h00);
            chk("rst_occ", k, occ[k], 0);
            chk("rst_ir", k, ir[k], 1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_seq(0);
        run_seq(1);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
